// File: rtl/bp_be_pkg.sv
// Shared types and constants for the back-end prefetch sequencer.
package bp_be_pkg;

  localparam int unsigned page_offset_lp      = 12;
  localparam int unsigned desc_vaddr_width_lp = 39;
  localparam int unsigned desc_stride_width_lp = 8;
  localparam int unsigned desc_count_width_lp  = 8;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_issue = 2'd1,
    e_skip  = 2'd2
  } bp_be_pref_seq_state_e;

  typedef struct packed {
    logic [desc_vaddr_width_lp-1:0]  pc;
    logic [desc_vaddr_width_lp-1:0]  eff_addr;
    logic [desc_stride_width_lp-1:0] stride;
    logic [desc_count_width_lp-1:0]  count;
  } bp_be_pref_desc_s;

endpackage

// File: rtl/bp_be_pref_desc_buffer.sv
// One-entry descriptor holding slot: fills when empty, drains on yumi_i, flushed by clear_i.
module bp_be_pref_desc_buffer #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic               v_q, v_d;
  logic [width_p-1:0] data_q, data_d;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (v_i & ~v_q) begin
      v_d    = 1'b1;
      data_d = data_i;
    end
    if (yumi_i)  v_d = 1'b0;
    if (clear_i) v_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign ready_o = ~v_q;
  assign v_o     = v_q;
  assign data_o  = data_q;

endmodule

// File: rtl/bp_be_prefetch_sequencer.sv
// Expands a loop-stride descriptor into page-bounded, one-per-cycle prefetch requests.
// Optional same-block suppression is enabled by defining BP_BE_PREFETCH_DEDUP_EN.
module bp_be_prefetch_sequencer
  import bp_be_pkg::*;
#(
  parameter int unsigned vaddr_width_p        = 39,
  parameter int unsigned stride_width_p       = 8,
  parameter int unsigned loop_range_p         = 8,
  parameter int unsigned max_degree_p         = 4,
  parameter int unsigned block_offset_width_p = 6
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  output logic                      ready_and_o,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [loop_range_p-1:0]   count_i,
  input  logic                      clear_i,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [vaddr_width_p-1:0]  pc_o,
  output logic [vaddr_width_p-1:0]  vaddr_o,
  output logic                      busy_o
);

  localparam int unsigned left_width_lp = $clog2(max_degree_p + 1);
  localparam int unsigned page_width_lp = vaddr_width_p - page_offset_lp;
  localparam int unsigned sum_width_lp  = vaddr_width_p + 1;
  localparam int unsigned ext_width_lp  = sum_width_lp - stride_width_p;
  localparam int unsigned desc_width_lp = 2 * vaddr_width_p + stride_width_p + loop_range_p;

  localparam logic [1:0] idle_s  = 2'(e_idle);
  localparam logic [1:0] issue_s = 2'(e_issue);

  if (max_degree_p < 1 || block_offset_width_p >= page_offset_lp || vaddr_width_p <= page_offset_lp)
    begin : g_cfg_check
      $error("bp_be_prefetch_sequencer: illegal parameterisation");
    end

  logic [1:0]                state_q, state_d;
  logic [vaddr_width_p-1:0]  pc_q, pc_d, cur_q, cur_d;
  logic [page_width_lp-1:0]  page_q, page_d;
  logic [stride_width_p-1:0] stride_q, stride_d;
  logic [left_width_lp-1:0]  left_q, left_d;
  logic                      v_q, v_d;

  logic                      accept, push, pop, need_load, advance, do_load;
  logic                      pend_v, pend_ready;
  logic [desc_width_lp-1:0]  pend_data;
  logic [vaddr_width_p-1:0]  pend_pc, pend_eff;
  logic [stride_width_p-1:0] pend_stride;
  logic [loop_range_p-1:0]   pend_count;

  assign ready_and_o = pend_ready & ~clear_i & reset_n_i;
  assign accept      = v_i & ready_and_o;

  bp_be_pref_desc_buffer #(.width_p(desc_width_lp)) pending (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_i),
    .v_i       (push),
    .data_i    ({pc_i, eff_addr_i, stride_i, count_i}),
    .ready_o   (pend_ready),
    .v_o       (pend_v),
    .data_o    (pend_data),
    .yumi_i    (pop)
  );

  assign {pend_pc, pend_eff, pend_stride, pend_count} = pend_data;

  // A held descriptor always has precedence over a newly arriving one.
  logic [vaddr_width_p-1:0]  ld_pc, ld_eff;
  logic [stride_width_p-1:0] ld_stride;
  logic [loop_range_p-1:0]   ld_count;
  logic [sum_width_lp-1:0]   ld_sum, adv_sum;
  logic [left_width_lp-1:0]  ld_left, adv_left;
  logic                      ld_ok, adv_ok;

  assign ld_pc     = pend_v ? pend_pc     : pc_i;
  assign ld_eff    = pend_v ? pend_eff    : eff_addr_i;
  assign ld_stride = pend_v ? pend_stride : stride_i;
  assign ld_count  = pend_v ? pend_count  : count_i;

  // Extra top bit flags wrap past either end of the address space as an off-page move.
  assign ld_sum  = {1'b0, ld_eff} + {{ext_width_lp{ld_stride[stride_width_p-1]}}, ld_stride};
  assign adv_sum = {1'b0, cur_q}  + {{ext_width_lp{stride_q[stride_width_p-1]}}, stride_q};

  always_comb begin
    ld_left = '0;
    if (ld_count == '0)
      ld_left = '0;
    else if (ld_stride == '0)
      ld_left = left_width_lp'(1);
    else if (ld_count > loop_range_p'(max_degree_p))
      ld_left = left_width_lp'(max_degree_p);
    else
      ld_left = left_width_lp'(ld_count);
  end

  assign ld_ok = (ld_left != '0)
               & (ld_sum[sum_width_lp-1:page_offset_lp] == {1'b0, ld_eff[vaddr_width_p-1:page_offset_lp]});

  assign adv_left = left_q - left_width_lp'(1);
  assign adv_ok   = (adv_left != '0)
                  & (adv_sum[sum_width_lp-1:page_offset_lp] == {1'b0, page_q});

`ifdef BP_BE_PREFETCH_DEDUP_EN
  localparam int unsigned blk_width_lp = vaddr_width_p - block_offset_width_p;
  localparam logic [1:0]  skip_s       = 2'(e_skip);

  logic [blk_width_lp-1:0] last_blk_q, last_blk_d, cmp_blk;
  logic                    last_v_q, last_v_d, cmp_v, dup;

  // A retiring issue is the newest block, even before last_blk_q captures it.
  assign cmp_blk = (state_q == issue_s) ? cur_q[vaddr_width_p-1:block_offset_width_p] : last_blk_q;
  assign cmp_v   = (state_q == issue_s) | last_v_q;
  assign dup     = cmp_v & (adv_sum[vaddr_width_p-1:block_offset_width_p] == cmp_blk);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_blk_q <= '0;
      last_v_q   <= 1'b0;
    end else begin
      last_blk_q <= last_blk_d;
      last_v_q   <= last_v_d;
    end
  end
`endif

  // Sequencing: advance the active stream, refill from pending/input on termination.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cur_d     = cur_q;
    page_d    = page_q;
    stride_d  = stride_q;
    left_d    = left_q;
    need_load = 1'b0;
    advance   = 1'b0;
    do_load   = 1'b0;
    pop       = 1'b0;
`ifdef BP_BE_PREFETCH_DEDUP_EN
    last_blk_d = last_blk_q;
    last_v_d   = last_v_q;
`endif

    case (state_q)
      issue_s: advance = yumi_i;
`ifdef BP_BE_PREFETCH_DEDUP_EN
      skip_s:  advance = 1'b1;
`endif
      default: need_load = 1'b1;
    endcase

`ifdef BP_BE_PREFETCH_DEDUP_EN
    if ((state_q == issue_s) && yumi_i) begin
      last_blk_d = cur_q[vaddr_width_p-1:block_offset_width_p];
      last_v_d   = 1'b1;
    end
`endif

    if (advance) begin
      cur_d  = adv_sum[vaddr_width_p-1:0];
      left_d = adv_left;
      if (adv_ok) begin
`ifdef BP_BE_PREFETCH_DEDUP_EN
        state_d = dup ? skip_s : issue_s;
`else
        state_d = issue_s;
`endif
      end else begin
        need_load = 1'b1;
      end
    end

    if (need_load) begin
      if (pend_v) begin
        pop     = 1'b1;
        do_load = 1'b1;
      end else if (accept) begin
        do_load = 1'b1;
      end else begin
        state_d = idle_s;
      end
    end

    if (do_load) begin
      pc_d     = ld_pc;
      page_d   = ld_eff[vaddr_width_p-1:page_offset_lp];
      cur_d    = ld_sum[vaddr_width_p-1:0];
      stride_d = ld_stride;
      left_d   = ld_left;
      state_d  = ld_ok ? issue_s : idle_s;
`ifdef BP_BE_PREFETCH_DEDUP_EN
      last_v_d = 1'b0;
`endif
    end

    if (clear_i) begin
      state_d = idle_s;
`ifdef BP_BE_PREFETCH_DEDUP_EN
      last_v_d = 1'b0;
`endif
    end

    v_d = (state_d == issue_s);
  end

  // An accepted descriptor goes to the slot unless it was loaded straight into the active set.
  assign push = accept & ~need_load;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= idle_s;
      pc_q     <= '0;
      cur_q    <= '0;
      page_q   <= '0;
      stride_q <= '0;
      left_q   <= '0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cur_q    <= cur_d;
      page_q   <= page_d;
      stride_q <= stride_d;
      left_q   <= left_d;
      v_q      <= v_d;
    end
  end

  assign v_o     = v_q;
  assign vaddr_o = cur_q;
  assign pc_o    = pc_q;
  assign busy_o  = (state_q != idle_s) | pend_v;

endmodule

// File: tb/tb_bp_be_prefetch_sequencer.sv
// Scoreboard bench for bp_be_prefetch_sequencer (default parameters).
module tb_bp_be_prefetch_sequencer;
  import bp_be_pkg::*;

  typedef struct packed {
    logic [38:0] pc;
    logic [38:0] vaddr;
  } req_s;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i, ready_and_o, clear_i, v_o, yumi_i, busy_o;
  logic [38:0] pc_i, eff_addr_i, pc_o, vaddr_o;
  logic [7:0]  stride_i, count_i;

  int   checks   = 0;
  int   failures = 0;
  int   issued   = 0;
  bit   yumi_en  = 1'b0;
  req_s q[$];

  bp_be_prefetch_sequencer dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (v_i),
    .ready_and_o (ready_and_o),
    .pc_i        (pc_i),
    .eff_addr_i  (eff_addr_i),
    .stride_i    (stride_i),
    .count_i     (count_i),
    .clear_i     (clear_i),
    .v_o         (v_o),
    .yumi_i      (yumi_i),
    .pc_o        (pc_o),
    .vaddr_o     (vaddr_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Consumer: accept whenever enabled, compare each handshake against the scoreboard.
  always @(negedge clk_i) begin
    if (v_o && yumi_en) begin
      req_s exp;
      checks++;
      issued++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_req: got pc=%h vaddr=%h, required no request", pc_o, vaddr_o);
      end else begin
        exp = q.pop_front();
        if ({pc_o, vaddr_o} !== exp) begin
          failures++;
          $display("FAIL req_data: got pc=%h vaddr=%h, required pc=%h vaddr=%h",
                   pc_o, vaddr_o, exp.pc, exp.vaddr);
        end
      end
      yumi_i = 1'b1;
    end else begin
      yumi_i = 1'b0;
    end
  end

  // Reference: expected request stream for one descriptor.
  function automatic void push_model(input bp_be_pref_desc_s d);
    logic [39:0] a, s;
    int          left;
    req_s        r;
    s = {{32{d.stride[7]}}, d.stride};
    a = {1'b0, d.eff_addr} + s;
    if (d.count == 8'd0)      left = 0;
    else if (d.stride == 8'd0) left = 1;
    else if (d.count > 8'd4)   left = 4;
    else                       left = int'(d.count);
    while (left > 0 && a[39:12] == {1'b0, d.eff_addr[38:12]}) begin
      r.pc    = d.pc;
      r.vaddr = a[38:0];
      q.push_back(r);
      a = a + s;
      left--;
    end
  endfunction

  function automatic bp_be_pref_desc_s mk(input logic [38:0] pc, input logic [38:0] eff,
                                          input logic [7:0] st, input logic [7:0] cnt);
    bp_be_pref_desc_s d;
    d.pc = pc; d.eff_addr = eff; d.stride = st; d.count = cnt;
    return d;
  endfunction

  task automatic send(input bp_be_pref_desc_s d, input bit track);
    bit got = 1'b0;
    @(posedge clk_i); #1;
    v_i = 1'b1; pc_i = d.pc; eff_addr_i = d.eff_addr; stride_i = d.stride; count_i = d.count;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_i);
      if (ready_and_o) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL send_timeout: ready_and_o=0 for 100 cycles, required 1");
    end else if (track) begin
      push_model(d);
    end
    @(posedge clk_i); #1;
    v_i = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_i);
      if (q.size() == 0 && !busy_o && !v_o) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain: busy_o=%0b v_o=%0b outstanding=%0d, required idle with 0 outstanding",
               name, busy_o, v_o, q.size());
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; v_i = 1'b1; clear_i = 1'b0; yumi_en = 1'b0;
    pc_i = '0; eff_addr_i = '0; stride_i = '0; count_i = 8'd1;
    repeat (3) @(negedge clk_i);
    checks += 5;
    if (v_o !== 1'b0)         begin failures++; $display("FAIL rst_v_o: got %b required 0", v_o); end
    if (ready_and_o !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b required 0", ready_and_o); end
    if (busy_o !== 1'b0)      begin failures++; $display("FAIL rst_busy: got %b required 0", busy_o); end
    if (vaddr_o !== 39'd0)    begin failures++; $display("FAIL rst_vaddr: got %h required 0", vaddr_o); end
    if (pc_o !== 39'd0)       begin failures++; $display("FAIL rst_pc: got %h required 0", pc_o); end
    v_i = 1'b0;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    yumi_en = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ready_and_o !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b required 1", ready_and_o); end
  endtask

  task automatic test_basic();
    int start = issued;
    send(mk(39'h40_0100, 39'h1000, 8'd64, 8'd10), 1'b1);
    @(negedge clk_i);
    checks++;
    if (v_o !== 1'b1 || vaddr_o !== 39'h1040) begin
      failures++;
      $display("FAIL basic_latency: got v_o=%b vaddr=%h, required v_o=1 vaddr=0001040", v_o, vaddr_o);
    end
    drain("basic");
    checks++;
    if (issued - start != 4) begin
      failures++;
      $display("FAIL basic_count: got %0d requests, required 4", issued - start);
    end
  endtask

  task automatic test_page_cross();
    int start = issued;
    send(mk(39'h40_0200, 39'h1F80, 8'd64, 8'd8), 1'b1);
    drain("page_cross");
    checks++;
    if (issued - start != 1) begin
      failures++;
      $display("FAIL page_cross_count: got %0d requests, required 1", issued - start);
    end
  endtask

  task automatic test_backpressure();
    yumi_en = 1'b0;
    send(mk(39'h40_0300, 39'h3100, 8'h80, 8'd2), 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (v_o !== 1'b1 || vaddr_o !== 39'h3080 || pc_o !== 39'h40_0300) begin
        failures++;
        $display("FAIL stall_hold%0d: got v_o=%b vaddr=%h pc=%h, required v_o=1 vaddr=0003080 pc=0000400300",
                 i, v_o, vaddr_o, pc_o);
      end
    end
    #1 yumi_en = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_back_to_back();
    bp_be_pref_desc_s a, b;
    a = mk(39'h40_0400, 39'h5000, 8'd64, 8'd3);
    b = mk(39'h40_0500, 39'h6000, 8'd32, 8'd2);
    @(posedge clk_i); #1;
    v_i = 1'b1; pc_i = a.pc; eff_addr_i = a.eff_addr; stride_i = a.stride; count_i = a.count;
    @(negedge clk_i);
    checks++;
    if (ready_and_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_a: got %b required 1", ready_and_o); end
    push_model(a);
    @(posedge clk_i); #1;
    pc_i = b.pc; eff_addr_i = b.eff_addr; stride_i = b.stride; count_i = b.count;
    @(negedge clk_i);
    checks++;
    if (ready_and_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_b: got %b required 1", ready_and_o); end
    push_model(b);
    checks++;
    if (v_o !== 1'b1) begin failures++; $display("FAIL b2b_cont0: got v_o=%b required 1", v_o); end
    @(posedge clk_i); #1;
    v_i = 1'b0;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk_i);
      checks++;
      if (v_o !== (i < 5)) begin
        failures++;
        $display("FAIL b2b_cont%0d: got v_o=%b required %b", i, v_o, (i < 5));
      end
    end
    drain("back_to_back");
  endtask

  task automatic test_clear();
    yumi_en = 1'b0;
    send(mk(39'h40_0600, 39'h7000, 8'd64, 8'd4), 1'b0);
    send(mk(39'h40_0700, 39'h8000, 8'd64, 8'd2), 1'b0);
    @(posedge clk_i); #1;
    v_i = 1'b1; pc_i = 39'h40_0800; eff_addr_i = 39'h9000; stride_i = 8'd64; count_i = 8'd2;
    clear_i = 1'b1;
    @(negedge clk_i);
    checks += 2;
    if (ready_and_o !== 1'b0) begin failures++; $display("FAIL clr_ready: got %b required 0", ready_and_o); end
    if (busy_o !== 1'b1)      begin failures++; $display("FAIL clr_busy_before: got %b required 1", busy_o); end
    @(posedge clk_i); #1;
    clear_i = 1'b0; v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checks++;
      if (v_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL clr_after%0d: got v_o=%b busy_o=%b, required 0 0", i, v_o, busy_o);
      end
    end
    // Clear while idle must still refuse a same-cycle descriptor.
    @(posedge clk_i); #1;
    v_i = 1'b1; clear_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ready_and_o !== 1'b0) begin failures++; $display("FAIL clr_idle_ready: got %b required 0", ready_and_o); end
    @(posedge clk_i); #1;
    v_i = 1'b0; clear_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (v_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL clr_idle_accept: got v_o=%b busy_o=%b, required 0 0", v_o, busy_o);
    end
    yumi_en = 1'b1;
  endtask

  task automatic test_zero_and_edges();
    send(mk(39'h40_0900, 39'h2000, 8'd64, 8'd0), 1'b1);
    @(negedge clk_i);
    checks++;
    if (v_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL zero_count: got v_o=%b busy_o=%b, required 0 0", v_o, busy_o);
    end
    send(mk(39'h40_0A00, 39'h2000, 8'd0, 8'd5), 1'b1);
    drain("zero_stride");
    send(mk(39'h40_0B00, 39'h2FC0, 8'd64, 8'd3), 1'b1);
    @(negedge clk_i);
    checks++;
    if (v_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL first_off_page: got v_o=%b busy_o=%b, required 0 0", v_o, busy_o);
    end
    send(mk(39'h40_0C00, 39'h7F_FFFF_FFC0, 8'd64, 8'd3), 1'b1);
    @(negedge clk_i);
    checks++;
    if (v_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL top_wrap: got v_o=%b busy_o=%b, required 0 0", v_o, busy_o);
    end
    drain("edges");
  endtask

  task automatic test_random();
    logic [7:0] st_tab [4];
    st_tab[0] = 8'h40; st_tab[1] = 8'hC0; st_tab[2] = 8'h80; st_tab[3] = 8'h00;
    for (int n = 0; n < 16; n++) begin
      send(mk(39'($urandom_range(0, 32'hFFFF)), 39'($urandom_range(0, 32'hFFFFF)),
              st_tab[$urandom_range(0, 3)], 8'($urandom_range(0, 9))), 1'b1);
    end
    drain("random");
  endtask

`ifdef BP_BE_PREFETCH_DEDUP_EN
  task automatic test_dedup();
    int   start = issued;
    req_s r;
    send(mk(39'h40_0D00, 39'h1030, 8'd16, 8'd4), 1'b0);
    r.pc = 39'h40_0D00; r.vaddr = 39'h1040;
    q.push_back(r);
    drain("dedup");
    checks++;
    if (issued - start != 1) begin
      failures++;
      $display("FAIL dedup_count: got %0d requests, required 1", issued - start);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_page_cross();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_zero_and_edges();
`ifdef BP_BE_PREFETCH_DEDUP_EN
    test_dedup();
`else
    test_random();
`endif
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d outstanding expected requests, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
